// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute stage and byte-addressed data memory.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned h/w accesses into byte beats.
module lsu_ctrl #(
    parameter logic [31:0] ERR_DATA = 32'hDEADC0DE
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWe,
    input  logic [2:0]  reqSize,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respErr,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [2:0]  memSize,
    output logic        memWEn,
    input  logic [31:0] memRData
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACCESS, ERROR, SPLIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_t;
`endif

    state_t      state, stateNext;
    logic        weR;
    logic [2:0]  sizeR;
    logic [31:0] addrR;
    logic [31:0] wdataR;
    logic        legal, aligned;
    logic        done, doneErr;
    logic [31:0] loadRaw;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  beat;
    logic [31:0] asmData, asmNext;
    logic        lastBeat;
`endif

    function automatic logic [31:0] extend(input logic [2:0] size, input logic [31:0] raw);
        case (size)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign reqReady = (state == IDLE);
    assign legal    = reqWe ? (reqSize == 3'b000 || reqSize == 3'b001 || reqSize == 3'b010)
                            : (reqSize == 3'b000 || reqSize == 3'b001 || reqSize == 3'b010 ||
                               reqSize == 3'b100 || reqSize == 3'b101);
    assign aligned  = (reqSize[1:0] == 2'b01) ? !reqAddr[0] :
                      (reqSize[1:0] == 2'b10) ? (reqAddr[1:0] == 2'b00) : 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign lastBeat = (beat == (sizeR[1] ? 2'd3 : 2'd1));
`endif

    // Write enable is gated by rstN so a reset asserted mid-access suppresses the pending beat.
    always_comb begin
        stateNext = state;
        memAddr   = 32'd0;
        memWData  = 32'd0;
        memSize   = 3'b010;
        memWEn    = 1'b0;
        done      = 1'b0;
        doneErr   = 1'b0;
        loadRaw   = memRData;
`ifdef LSU_MISALIGN_SPLIT_EN
        asmNext   = asmData;
        asmNext[{beat, 3'b000} +: 8] = memRData[7:0];
`endif
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    if (!legal)
                        stateNext = ERROR;
                    else if (aligned)
                        stateNext = ACCESS;
                    else
`ifdef LSU_MISALIGN_SPLIT_EN
                        stateNext = SPLIT;
`else
                        stateNext = ERROR;
`endif
                end
            end
            ACCESS: begin
                memAddr   = addrR;
                memSize   = sizeR;
                memWData  = wdataR;
                memWEn    = weR && rstN;
                done      = 1'b1;
                stateNext = IDLE;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                memAddr  = addrR + {30'd0, beat};
                memSize  = weR ? 3'b000 : 3'b100;
                memWData = {24'd0, wdataR[{beat, 3'b000} +: 8]};
                memWEn   = weR && rstN;
                loadRaw  = asmNext;
                if (lastBeat) begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end
            end
`endif
            ERROR: begin
                done      = 1'b1;
                doneErr   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request capture, beat sequencing and the registered completion pulse.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            respValid <= 1'b0;
            respData  <= 32'd0;
            respErr   <= 1'b0;
            weR       <= 1'b0;
            sizeR     <= 3'b000;
            addrR     <= 32'd0;
            wdataR    <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            beat      <= 2'd0;
            asmData   <= 32'd0;
`endif
        end else begin
            state     <= stateNext;
            respValid <= done;
            if (done) begin
                respErr  <= doneErr;
                respData <= doneErr ? ERR_DATA : (weR ? 32'd0 : extend(sizeR, loadRaw));
            end
            if (reqValid && reqReady) begin
                weR    <= reqWe;
                sizeR  <= reqSize;
                addrR  <= reqAddr;
                wdataR <= reqWData;
`ifdef LSU_MISALIGN_SPLIT_EN
                beat    <= 2'd0;
                asmData <= 32'd0;
            end else if (state == SPLIT) begin
                beat    <= beat + 2'd1;
                asmData <= asmNext;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array memory model, reference model at accept,
// monitor compares each respValid pulse against the queued expectation.
`timescale 1ns/1ps
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam logic [31:0] ERR_DATA = 32'hDEADC0DE;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, reqReady, reqWe;
    logic [2:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic        respValid, respErr;
    logic [31:0] respData;
    logic [31:0] memAddr, memWData, memRData;
    logic [2:0]  memSize;
    logic        memWEn;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } expT;

    expT         sb[$];
    logic [7:0]  memArr [logic [31:0]];
    logic [7:0]  refMem [logic [31:0]];
    int          memWrites = 0;
    int          cycle = 0;
    int          nChecks = 0;
    int          nFail = 0;
    bit          skipModel = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    lsu_ctrl #(.ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rstN(rstN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWe(reqWe), .reqSize(reqSize),
        .reqAddr(reqAddr), .reqWData(reqWData),
        .respValid(respValid), .respData(respData), .respErr(respErr),
        .memAddr(memAddr), .memWData(memWData), .memSize(memSize), .memWEn(memWEn),
        .memRData(memRData)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [7:0] dutByte(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : 8'h00;
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : 8'h00;
    endfunction

    // Memory returns junk above the requested width so the LSU must do its own extension.
    always @(memAddr, memSize, memWrites) begin
        case (memSize[1:0])
            2'b00:   memRData = {24'hA5A5A5, dutByte(memAddr)};
            2'b01:   memRData = {16'hA5A5, dutByte(memAddr + 32'd1), dutByte(memAddr)};
            default: memRData = {dutByte(memAddr + 32'd3), dutByte(memAddr + 32'd2),
                                 dutByte(memAddr + 32'd1), dutByte(memAddr)};
        endcase
    end

    always @(posedge clk) begin
        int n;
        if (memWEn) begin
            n = (memSize[1:0] == 2'b00) ? 1 : (memSize[1:0] == 2'b01) ? 2 : 4;
            for (int i = 0; i < n; i++)
                memArr[memAddr + 32'(i)] = memWData[8*i +: 8];
            memWrites++;
        end
    end

    // Reference model: whole-request semantics on a byte array, evaluated at accept.
    function automatic expT modelRequest(input logic we, input logic [2:0] size,
                                         input logic [31:0] addr, input logic [31:0] wdata);
        expT    e;
        int     n;
        bit     legal, isAligned;
        longint val;
        legal     = we ? (size inside {3'd0, 3'd1, 3'd2}) : (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n         = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
        isAligned = (addr % n) == 0;
        e.acc = 0;
        if (!legal || (!isAligned && !SPLIT_EN)) begin
            e.data = ERR_DATA;
            e.err  = 1'b1;
            e.lat  = 2;
        end else begin
            e.err = 1'b0;
            e.lat = isAligned ? 2 : n + 1;
            if (we) begin
                for (int i = 0; i < n; i++)
                    refMem[addr + 32'(i)] = wdata[8*i +: 8];
                e.data = 32'd0;
            end else begin
                val = 0;
                for (int i = 0; i < n; i++)
                    val += longint'(refByte(addr + 32'(i))) << (8 * i);
                if (!size[2] && n < 4 && val >= (longint'(1) << (8 * n - 1)))
                    val -= longint'(1) << (8 * n);
                e.data = val[31:0];
            end
        end
        return e;
    endfunction

    // Stimulus side: push the expected response for every accepted request.
    always @(negedge clk) begin
        expT e;
        if (rstN && reqValid && reqReady && !skipModel) begin
            e = modelRequest(reqWe, reqSize, reqAddr, reqWData);
            e.acc = cycle;
            sb.push_back(e);
        end
    end

    // Monitor side: every completion pulse pops one expectation.
    always @(negedge clk) begin
        expT e;
        if (rstN && respValid) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousResp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("respData", respData, e.data);
                checkOutput("respErr", {31'd0, respErr}, {31'd0, e.err});
                checkOutput("latency", 32'(cycle - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int guard = 0;
        reqValid = 1'b1;
        reqWe    = we;
        reqSize  = size;
        reqAddr  = addr;
        reqWData = wdata;
        @(negedge clk);
        while (!reqReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady) checkOutput("acceptTimeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWe    = 1'($urandom);
        reqSize  = 3'($urandom);
        reqAddr  = $urandom;
        reqWData = $urandom;
    endtask

    task automatic waitDrain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void seedByte(input logic [31:0] a, input logic [7:0] v);
        memArr[a] = v;
        refMem[a] = v;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          errSnap, bad;
        logic [7:0]  oldB, oldC;
        logic [31:0] a;
        rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqSize = 3'b000;
        reqAddr = 32'd0; reqWData = 32'd0;
        for (int i = 0; i < 96; i++) seedByte(32'h0F0 + 32'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) seedByte(32'hFFFFFFF0 + 32'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) seedByte(32'(i), 8'($urandom));
        seedByte(32'h100, 8'h78); seedByte(32'h101, 8'h56);
        seedByte(32'h102, 8'h34); seedByte(32'h103, 8'h12);
        seedByte(32'h104, 8'h80);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReqReady", {31'd0, reqReady}, 32'd1);
        checkOutput("rstRespValid", {31'd0, respValid}, 32'd0);
        checkOutput("rstRespData", respData, 32'd0);
        checkOutput("rstRespErr", {31'd0, respErr}, 32'd0);
        checkOutput("rstMemAddr", memAddr, 32'd0);
        checkOutput("rstMemWData", memWData, 32'd0);
        checkOutput("rstMemSize", {29'd0, memSize}, 32'd2);
        checkOutput("rstMemWEn", {31'd0, memWEn}, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 3'b010, 32'h100, 32'd0);
        applyStimulus(1'b0, 3'b000, 32'h104, 32'd0);
        applyStimulus(1'b0, 3'b100, 32'h104, 32'd0);
        waitDrain();
        errSnap = memWrites;
        applyStimulus(1'b0, 3'b011, 32'h100, 32'd0);
        applyStimulus(1'b1, 3'b100, 32'h108, 32'h55);
        applyStimulus(1'b0, 3'b001, 32'h103, 32'd0);
        waitDrain();
        checkOutput("noWriteOnErrOrLoad", 32'(memWrites - errSnap), 32'd0);

        if (SPLIT_EN) begin
            applyStimulus(1'b1, 3'b010, 32'h101, 32'hAABBCCDD);
            waitDrain();
            checkOutput("splitByte0", {24'd0, dutByte(32'h101)}, 32'hDD);
            checkOutput("splitByte1", {24'd0, dutByte(32'h102)}, 32'hCC);
            checkOutput("splitByte2", {24'd0, dutByte(32'h103)}, 32'hBB);
            checkOutput("splitByte3", {24'd0, dutByte(32'h104)}, 32'hAA);

            oldB = dutByte(32'h10B);
            oldC = dutByte(32'h10C);
            skipModel = 1'b1;
            applyStimulus(1'b1, 3'b010, 32'h109, 32'h11223344);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rstN = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("abortReqReady", {31'd0, reqReady}, 32'd1);
            checkOutput("abortRespValid", {31'd0, respValid}, 32'd0);
            checkOutput("abortByte0", {24'd0, dutByte(32'h109)}, 32'h44);
            checkOutput("abortByte1", {24'd0, dutByte(32'h10A)}, 32'h33);
            checkOutput("abortByte2", {24'd0, dutByte(32'h10B)}, {24'd0, oldB});
            checkOutput("abortByte3", {24'd0, dutByte(32'h10C)}, {24'd0, oldC});
            refMem[32'h109] = 8'h44;
            refMem[32'h10A] = 8'h33;
            rstN = 1'b1;
            skipModel = 1'b0;
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFA + 32'($urandom_range(0, 5))
                                            : 32'h100 + 32'($urandom_range(0, 63));
            applyStimulus(1'($urandom), 3'($urandom), a, $urandom);
        end
        waitDrain();

        bad = 0;
        foreach (refMem[x]) if (dutByte(x) !== refMem[x]) bad++;
        foreach (memArr[x]) if (!refMem.exists(x)) bad++;
        checkOutput("memImage", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
